// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and defaults for the instruction fetch unit.
//   XLEN_DEF / ILEN_DEF : default PC/address and instruction widths
//   PC_INC              : sequential PC step in bytes
//   fetch_state_e       : FETCH (issuing) / DRAIN (discarding stale responses)
//   fetch_entry_t       : {pc, instr} record at the default widths
package fetch_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned ILEN_DEF = 32;
    localparam int unsigned PC_INC   = 4;

    typedef enum logic [0:0] {
        FETCH,
        DRAIN
    } fetch_state_e;

    // Field order matches the {pc, instr} packing used in the instruction buffer.
    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [ILEN_DEF-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush, used for pending PCs and the
// decode instruction buffer.
//   clk, reset        : clock, synchronous active-high reset
//   flush             : empties the FIFO at the next edge (wins over push)
//   push, push_data   : write port; ignored when full
//   pop, pop_data     : read port; pop_data shows the head (valid when !empty)
//   count, empty, full: occupancy status
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    wr_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign count    = count_q;
    assign pop_data = mem[rd_ptr_q];
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction fetch with credit-limited requests, a
// decode-side instruction buffer, and redirect flush with stale-response drop.
//   clk, reset                         : clock, synchronous active-high reset
//   pc_in / pc_next / pc_en            : PC register data_out / data_in / enable
//   redirect_valid / redirect_pc       : branch/jump redirect
//   imem_req_valid/ready/addr          : memory request channel
//   imem_rsp_valid / imem_rsp_data     : in-order memory responses
//   out_valid/ready, out_pc, out_instr : decode handshake, head of buffer
// Optional: define FETCH_PERF_EN to add perf_stall_cnt / perf_flush_cnt
// (saturating 32-bit counters of stalled FETCH cycles and redirect cycles).
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned ILEN  = ILEN_DEF,
    parameter int unsigned DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_in,
    output logic [XLEN-1:0] pc_next,
    output logic            pc_en,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [ILEN-1:0] out_instr
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_stall_cnt,
    output logic [31:0]     perf_flush_cnt
`endif
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    fetch_state_e   state_q, state_d;
    logic [CW-1:0]  inflight_q, inflight_d;
    logic [CW-1:0]  drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]  remaining;
    logic [CW:0]    occupancy;
    logic           credit_ok;
    logic           issue;
    logic           req_hs;
    logic           rsp_ok;
    logic           rsp_take;

    logic [XLEN-1:0]      pend_pc;
    logic [CW-1:0]        pend_count;
    logic                 pend_empty;
    logic                 pend_full;
    logic [XLEN+ILEN-1:0] buf_head;
    logic [CW-1:0]        buf_count;
    logic                 buf_empty;
    logic                 buf_full;

    // Outstanding requests plus buffered entries never exceed DEPTH, so a
    // response always has a buffer slot.
    assign occupancy = {1'b0, inflight_q} + {1'b0, buf_count};
    assign credit_ok = occupancy < (CW + 1)'(DEPTH);
    assign issue     = ~reset & (state_q == FETCH) & credit_ok & ~redirect_valid;
    assign req_hs    = issue & imem_req_ready;

    // A response with nothing outstanding is ignored.
    assign rsp_ok    = ~reset & imem_rsp_valid & (inflight_q != '0);
    assign rsp_take  = rsp_ok & (state_q == FETCH) & ~redirect_valid;
    assign remaining = inflight_q - CW'(rsp_ok);

    assign imem_req_valid = issue;
    assign imem_req_addr  = pc_in;
    assign pc_en          = ~reset & (redirect_valid | req_hs);
    assign pc_next        = redirect_valid ? redirect_pc : pc_in + XLEN'(PC_INC);

    assign out_valid = ~reset & ~buf_empty;
    assign out_pc    = buf_head[XLEN+ILEN-1:ILEN];
    assign out_instr = buf_head[ILEN-1:0];

    fetch_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_pend_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (req_hs),
        .push_data (pc_in),
        .pop       (rsp_take),
        .pop_data  (pend_pc),
        .count     (pend_count),
        .empty     (pend_empty),
        .full      (pend_full)
    );

    fetch_fifo #(
        .WIDTH (XLEN + ILEN),
        .DEPTH (DEPTH)
    ) u_instr_buf (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (rsp_take),
        .push_data ({pend_pc, imem_rsp_data}),
        .pop       (out_valid & out_ready),
        .pop_data  (buf_head),
        .count     (buf_count),
        .empty     (buf_empty),
        .full      (buf_full)
    );

    always_comb begin
        state_d    = state_q;
        inflight_d = inflight_q;
        drop_cnt_d = drop_cnt_q;
        if (redirect_valid) begin
            // Everything still outstanding after this cycle is stale.
            inflight_d = remaining;
            drop_cnt_d = remaining;
            state_d    = (remaining != '0) ? DRAIN : FETCH;
        end else begin
            unique case (state_q)
                FETCH: begin
                    inflight_d = inflight_q + CW'(req_hs) - CW'(rsp_take);
                end
                DRAIN: begin
                    if (rsp_ok) begin
                        inflight_d = inflight_q - 1'b1;
                        drop_cnt_d = drop_cnt_q - 1'b1;
                        if (drop_cnt_q == CW'(1)) state_d = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FETCH;
            inflight_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if ((state_q == FETCH) && !req_hs && !redirect_valid && (perf_stall_cnt != '1)) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (redirect_valid && (perf_flush_cnt != '1)) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
        end
    end
`endif

`ifndef SYNTHESIS
    rsp_without_request: assert property (@(posedge clk) disable iff (reset)
        imem_rsp_valid |-> (inflight_q != '0));
    pend_tracks_inflight: assert property (@(posedge clk) disable iff (reset)
        (state_q == FETCH) |-> (pend_count == inflight_q));
    rsp_has_pending_pc: assert property (@(posedge clk) disable iff (reset)
        rsp_take |-> !pend_empty);
    no_push_when_full: assert property (@(posedge clk) disable iff (reset)
        !((req_hs && pend_full) || (rsp_take && buf_full)));
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed, table-driven bench for fetch_unit with a PC
// register and a fixed-latency in-order memory model.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned ILEN  = 32;
    localparam int unsigned DEPTH = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [XLEN-1:0] pc_in;
    logic [XLEN-1:0] pc_next;
    logic            pc_en;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [ILEN-1:0] imem_rsp_data;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [ILEN-1:0] out_instr;
`ifdef FETCH_PERF_EN
    logic [31:0]     perf_stall_cnt;
    logic [31:0]     perf_flush_cnt;
`endif

    always #5 clk = ~clk;

    fetch_unit #(
        .XLEN  (XLEN),
        .ILEN  (ILEN),
        .DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .pc_in          (pc_in),
        .pc_next        (pc_next),
        .pc_en          (pc_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr)
`ifdef FETCH_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    typedef struct {
        logic [XLEN-1:0] addr;
        int              due;
    } mreq_t;

    typedef struct {
        bit              rst;
        logic [XLEN-1:0] rst_pc;
        bit              out_rdy;
        bit              req_rdy;
        bit              e_req;
        logic [XLEN-1:0] e_addr;
        bit              e_pc_en;
        logic [XLEN-1:0] e_next;
        bit              e_out;
        logic [XLEN-1:0] e_out_pc;
        int              e_stall;   // -1: not checked
    } vec_t;

    mreq_t           mq[$];
    int              lat;
    int              cyc;
    logic [XLEN-1:0] pc_reg;
    int              checks;
    int              errors;

    logic            s_req_valid, s_req_ready, s_pc_en, s_out_valid, s_rsp, s_reset;
    logic [XLEN-1:0] s_addr, s_pc_next, s_out_pc;
    logic [ILEN-1:0] s_out_instr;

    function automatic logic [ILEN-1:0] mem_word(input logic [XLEN-1:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_rsp();
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mq[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    endtask

    task automatic sample();
        @(negedge clk);
        s_req_valid = imem_req_valid;
        s_req_ready = imem_req_ready;
        s_addr      = imem_req_addr;
        s_pc_en     = pc_en;
        s_pc_next   = pc_next;
        s_out_valid = out_valid;
        s_out_pc    = out_pc;
        s_out_instr = out_instr;
        s_rsp       = imem_rsp_valid;
        s_reset     = reset;
    endtask

    // Clock edge, then update the PC register and memory models.
    task automatic advance();
        @(posedge clk);
        #1;
        if (s_reset) begin
            mq.delete();
        end else begin
            if (s_rsp) void'(mq.pop_front());
            if (s_req_valid && s_req_ready) mq.push_back('{addr: s_addr, due: cyc + lat});
        end
        if (s_pc_en) pc_reg = s_pc_next;
        pc_in = pc_reg;
        cyc++;
        drive_rsp();
    endtask

    task automatic do_reset(input logic [XLEN-1:0] start_pc);
        reset          = 1'b1;
        redirect_valid = 1'b0;
        pc_reg         = start_pc;
        pc_in          = start_pc;
        sample();
        advance();
        sample();
        advance();
        reset = 1'b0;
    endtask

    task automatic wait_out(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            sample();
            if (s_out_valid) begin
                ok = 1'b1;
                break;
            end
            advance();
        end
    endtask

    vec_t vecs[$];
    bit   ok;

    initial begin
        checks         = 0;
        errors         = 0;
        cyc            = 0;
        lat            = 1;
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        out_ready      = 1'b1;
        pc_reg         = '0;
        pc_in          = '0;

        // Reset outputs
        sample();
        advance();
        sample();
        check("reset_req_valid", s_req_valid, 0);
        check("reset_pc_en", s_pc_en, 0);
        check("reset_out_valid", s_out_valid, 0);
        advance();
        reset = 1'b0;

        // rst rst_pc  ordy rrdy req addr     pc_en next     out out_pc   stall
        // Sequential streaming, 1-cycle memory
        vecs.push_back('{1, 32'h00, 1, 1, 1, 32'h00, 1, 32'h04, 0, 32'h0, -1});
        vecs.push_back('{0, 32'h00, 1, 1, 1, 32'h04, 1, 32'h08, 0, 32'h0, -1});
        vecs.push_back('{0, 32'h00, 1, 1, 1, 32'h08, 1, 32'h0C, 1, 32'h0, -1});
        vecs.push_back('{0, 32'h00, 1, 1, 1, 32'h0C, 1, 32'h10, 1, 32'h4, -1});
        vecs.push_back('{0, 32'h00, 1, 1, 1, 32'h10, 1, 32'h14, 1, 32'h8, -1});
        // Decode backpressure fills the buffer and stops issue at 0x10
        vecs.push_back('{1, 32'h00, 0, 1, 1, 32'h00, 1, 32'h04, 0, 32'h0, -1});
        vecs.push_back('{0, 32'h00, 0, 1, 1, 32'h04, 1, 32'h08, 0, 32'h0, -1});
        vecs.push_back('{0, 32'h00, 0, 1, 1, 32'h08, 1, 32'h0C, 1, 32'h0, -1});
        vecs.push_back('{0, 32'h00, 0, 1, 1, 32'h0C, 1, 32'h10, 1, 32'h0, -1});
        vecs.push_back('{0, 32'h00, 0, 1, 0, 32'h10, 0, 32'h00, 1, 32'h0, -1});
        vecs.push_back('{0, 32'h00, 0, 1, 0, 32'h10, 0, 32'h00, 1, 32'h0, -1});
        vecs.push_back('{0, 32'h00, 1, 1, 0, 32'h10, 0, 32'h00, 1, 32'h0, -1});
        vecs.push_back('{0, 32'h00, 1, 1, 1, 32'h10, 1, 32'h14, 1, 32'h4, -1});
        vecs.push_back('{0, 32'h00, 1, 1, 1, 32'h14, 1, 32'h18, 1, 32'h8, -1});
        // Memory not ready for 3 cycles at 0x20
        vecs.push_back('{1, 32'h20, 1, 0, 1, 32'h20, 0, 32'h00, 0, 32'h0, 0});
        vecs.push_back('{0, 32'h20, 1, 0, 1, 32'h20, 0, 32'h00, 0, 32'h0, -1});
        vecs.push_back('{0, 32'h20, 1, 0, 1, 32'h20, 0, 32'h00, 0, 32'h0, -1});
        vecs.push_back('{0, 32'h20, 1, 1, 1, 32'h20, 1, 32'h24, 0, 32'h0, 3});

        foreach (vecs[i]) begin
            if (vecs[i].rst) begin
                lat = 1;
                do_reset(vecs[i].rst_pc);
            end
            out_ready      = vecs[i].out_rdy;
            imem_req_ready = vecs[i].req_rdy;
            sample();
            check($sformatf("v%0d_req_valid", i), s_req_valid, vecs[i].e_req);
            check($sformatf("v%0d_req_addr", i), s_addr, vecs[i].e_addr);
            check($sformatf("v%0d_pc_en", i), s_pc_en, vecs[i].e_pc_en);
            if (vecs[i].e_pc_en) check($sformatf("v%0d_pc_next", i), s_pc_next, vecs[i].e_next);
            check($sformatf("v%0d_out_valid", i), s_out_valid, vecs[i].e_out);
            if (vecs[i].e_out) begin
                check($sformatf("v%0d_out_pc", i), s_out_pc, vecs[i].e_out_pc);
                check($sformatf("v%0d_out_instr", i), s_out_instr, mem_word(vecs[i].e_out_pc));
            end
`ifdef FETCH_PERF_EN
            if (vecs[i].e_stall >= 0) begin
                check($sformatf("v%0d_perf_stall", i), perf_stall_cnt, 64'(vecs[i].e_stall));
            end
`endif
            advance();
        end

        // Redirect with two requests outstanding, 3-cycle memory
        out_ready      = 1'b1;
        imem_req_ready = 1'b1;
        lat            = 3;
        do_reset(32'h0);
        sample(); check("rd_req0", s_addr, 32'h0); advance();
        sample(); check("rd_req1", s_addr, 32'h4); advance();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        sample();
        check("rd_no_issue", s_req_valid, 0);
        check("rd_pc_en", s_pc_en, 1);
        check("rd_pc_next", s_pc_next, 32'h100);
        advance();
        redirect_valid = 1'b0;
        sample();
        check("rd_drain0_req", s_req_valid, 0);
        check("rd_drain0_out", s_out_valid, 0);
        advance();
        sample();
        check("rd_drain1_req", s_req_valid, 0);
        check("rd_drain1_out", s_out_valid, 0);
        advance();
        sample();
        check("rd_resume_req", s_req_valid, 1);
        check("rd_resume_addr", s_addr, 32'h100);
        check("rd_resume_out", s_out_valid, 0);
`ifdef FETCH_PERF_EN
        check("rd_perf_flush", perf_flush_cnt, 1);
`endif
        advance();
        wait_out(10, ok);
        check("rd_out_timeout", ok, 1);
        check("rd_out_pc", s_out_pc, 32'h100);
        check("rd_out_instr", s_out_instr, mem_word(32'h100));
        advance();

        // Redirect coinciding with the only outstanding response
        lat = 2;
        do_reset(32'h0);
        sample(); check("rs_req0", s_addr, 32'h0); advance();
        imem_req_ready = 1'b0;
        sample();
        check("rs_stall_valid", s_req_valid, 1);
        check("rs_stall_pc_en", s_pc_en, 0);
        advance();
        imem_req_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        sample();
        check("rs_rsp_present", s_rsp, 1);
        check("rs_no_issue", s_req_valid, 0);
        check("rs_pc_next", s_pc_next, 32'h200);
        advance();
        redirect_valid = 1'b0;
        sample();
        check("rs_fetch_req", s_req_valid, 1);
        check("rs_fetch_addr", s_addr, 32'h200);
        check("rs_no_stale0", s_out_valid, 0);
        advance();
        sample(); check("rs_no_stale1", s_out_valid, 0); advance();
        sample(); check("rs_no_stale2", s_out_valid, 0); advance();
        wait_out(10, ok);
        check("rs_out_timeout", ok, 1);
        check("rs_out_pc", s_out_pc, 32'h200);
        advance();

        // Reset in the middle of DRAIN
        lat = 3;
        do_reset(32'h0);
        sample(); advance();
        sample(); advance();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        sample(); advance();
        redirect_valid = 1'b0;
        reset          = 1'b1;
        sample();
        check("rr_req_valid0", s_req_valid, 0);
        check("rr_pc_en0", s_pc_en, 0);
        check("rr_out_valid0", s_out_valid, 0);
        advance();
        sample();
        check("rr_req_valid1", s_req_valid, 0);
        check("rr_out_valid1", s_out_valid, 0);
        check("rr_state", 64'(dut.state_q), 64'(FETCH));
        check("rr_inflight", 64'(dut.inflight_q), 0);
        advance();
        reset = 1'b0;
        sample();
        check("rr_resume_req", s_req_valid, 1);
        check("rr_resume_addr", s_addr, 32'h100);
        advance();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Reader side of the PC register: consumes the current PC (register data_out) and drives the register's data_in/enable.
- Issues in-order instruction-memory requests and collects the responses.
- Buffers fetched {pc, instr} pairs for decode behind a valid/ready handshake.
- Handles redirects: flushes in-flight work and discards stale responses.

Parameters:
- XLEN, 32, PC and address width
- ILEN, 32, instruction width
- DEPTH, 4, instruction buffer entries; also the maximum in-flight requests (credit limit); power of two, at least 2

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- pc_in  in  XLEN  current PC from PC register data_out
- pc_next  out  XLEN  to PC register data_in
- pc_en  out  1  to PC register enable; 0 holds the PC
- redirect_valid  in  1  branch/jump redirect request
- redirect_pc  in  XLEN  redirect target
- imem_req_valid  out  1  memory request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  request address
- imem_rsp_valid  in  1  response valid; in order, at least 1 cycle after its request
- imem_rsp_data  in  ILEN  instruction word
- out_valid  out  1  decode entry valid
- out_ready  in  1  decode accepts entry
- out_pc  out  XLEN  PC of the entry
- out_instr  out  ILEN  instruction of the entry

Behaviour:
- Interface is fixed: one clock, clk; reset is synchronous and active-high, named reset.
- State machine, package enum: FETCH, DRAIN.
- Reset (sync): state=FETCH; inflight=0; drop_cnt=0; both FIFOs empty.
  - Outputs during reset: imem_req_valid=0, pc_en=0, out_valid=0.
- Credits: credit_ok when inflight + buf_count < DEPTH.
- issue = (state==FETCH) & credit_ok & ~redirect_valid.
  - imem_req_valid=issue.
  - imem_req_addr=pc_in, combinational.
- On handshake (imem_req_valid & imem_req_ready):
  - pc_en=1, pc_next=pc_in+4; wraps mod 2^XLEN.
  - pc_in is pushed into the pending-PC FIFO.
  - inflight increments.
- No handshake and no redirect: pc_en=0 and the PC holds.
  - imem_req_valid stays high while the issue condition persists.
  - imem_req_addr stays stable while valid and not ready.
- Response in FETCH:
  - Pops the pending-PC FIFO.
  - Pushes {pc, rsp_data} into the instruction buffer.
  - Decrements inflight.
- Response and request handshake in the same cycle: inflight is unchanged.
- out_valid = buffer not empty; out_pc/out_instr show the head entry.
  - Pop on out_valid & out_ready.
  - Push and pop in the same cycle are allowed.
  - Credits guarantee there is never a push when full.
- Redirect, any state:
  - pc_en=1, pc_next=redirect_pc; takes priority over the increment.
  - No request is issued that cycle.
  - Both FIFOs are flushed; empty the next cycle.
  - A response arriving in the same cycle is discarded.
  - drop_cnt <= inflight - imem_rsp_valid; inflight <= that same value.
  - Next state = DRAIN if the value is nonzero, else FETCH.
- DRAIN:
  - No issue; each response is discarded and decrements drop_cnt and inflight.
  - When the last stale response arrives, go to FETCH the next cycle.
  - A repeated redirect in DRAIN only reloads the PC; drop_cnt continues counting down.
- imem_rsp_valid with inflight==0: ignored; simulation assertion fires.
- Latency: response to out_valid is 1 cycle (registered buffer).
- Redirect to first request: 1 cycle if nothing is in flight.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined: adds outputs perf_stall_cnt[31:0] and perf_flush_cnt[31:0].
  - perf_stall_cnt counts FETCH cycles with no handshake and no redirect.
  - perf_flush_cnt counts redirect cycles.
  - Both saturate at all-ones; reset to 0.
- Undefined: ports and logic absent; no other behaviour changes.

Decomposition:
- Package fetch_pkg:
  - XLEN_DEF, ILEN_DEF, PC_INC=4.
  - state enum fetch_state_e {FETCH, DRAIN}.
  - Packed struct fetch_entry_t {pc, instr}.
- Sub-module fetch_fifo:
  - Parameterised width/depth.
  - Synchronous reset and flush; push/pop; count/empty/full.
  - Instantiated twice: pending-PC FIFO and instruction buffer.

Test Plan:
- Reset, then pc_in=0x0, req_ready=1, 1-cycle memory, out_ready=1:
  - Requests issue at 0x0, 0x4, 0x8.
  - pc_next=0x4, 0x8, 0xC with pc_en=1.
  - Outputs appear in order with matching instrs.
- out_ready=0 with a 1-cycle memory:
  - After 4 entries are buffered, imem_req_valid=0 and pc_en=0; PC holds 0x10.
  - Raising out_ready resumes issue.
- req_ready low 3 cycles at pc_in=0x20:
  - imem_req_addr holds 0x20 and pc_en=0.
  - perf_stall_cnt=3 when FETCH_PERF_EN is defined.
- Redirect to 0x100 with 2 requests outstanding, 3-cycle memory:
  - Both stale responses are dropped (state DRAIN).
  - Buffer is empty; next request is at 0x100.
  - out_pc of the next entry = 0x100.
- Redirect while a response arrives in the same cycle, 1 outstanding:
  - Response is dropped; next state is FETCH.
  - No stale entry reaches out_valid.
- Reset asserted mid-DRAIN with 2 outstanding:
  - Next cycle: state=FETCH, inflight=0, out_valid=0, imem_req_valid=0 while reset is held.
